// File: rtl/umi_packet_fifo.sv
// First-word-fall-through FIFO holding whole UMI packets; push into empty shows on out_valid next cycle.
// Backpressure: in_ready = !full and out_valid = !empty, both decoded from registered pointers only.
module umi_packet_fifo #(
    parameter int AW    = 64,
    parameter int CW    = 32,
    parameter int UW    = 256,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [CW-1:0]            in_cmd,
    input  logic [AW-1:0]            in_dstaddr,
    input  logic [AW-1:0]            in_srcaddr,
    input  logic [UW-1:0]            in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [CW-1:0]            packet_cmd,
    output logic [AW-1:0]            packet_dst_addr,
    output logic [AW-1:0]            packet_src_addr,
    output logic [UW-1:0]            packet_payload,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);

    typedef struct packed {
        logic [CW-1:0] cmd;
        logic [AW-1:0] dst;
        logic [AW-1:0] src;
        logic [UW-1:0] data;
    } pkt_t;

    pkt_t        r_mem [DEPTH];
    logic [PW:0] r_wr_ptr;
    logic [PW:0] r_rd_ptr;
    logic [PW:0] r_count;

    logic        w_empty;
    logic        w_full;
    logic        w_push;
    logic        w_pop;
    pkt_t        w_head;

    // Extra MSB on each pointer distinguishes full from empty when low bits match.
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[PW-1:0] == r_rd_ptr[PW-1:0]) && (r_wr_ptr[PW] != r_rd_ptr[PW]);
    assign w_push  = in_valid && !w_full;
    assign w_pop   = !w_empty && out_ready;

    assign in_ready  = !w_full;
    assign out_valid = !w_empty;
    assign count     = r_count;

    assign w_head          = r_mem[r_rd_ptr[PW-1:0]];
    assign packet_cmd      = w_head.cmd;
    assign packet_dst_addr = w_head.dst;
    assign packet_src_addr = w_head.src;
    assign packet_payload  = w_head.data;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // Storage carries no reset; a full FIFO never accepts, so the head slot is never overwritten.
    always_ff @(posedge clk) begin
        if (w_push && !reset && !flush) begin
            r_mem[r_wr_ptr[PW-1:0]] <= '{cmd: in_cmd, dst: in_dstaddr, src: in_srcaddr, data: in_data};
        end
    end

endmodule
